// File: rtl/pixel_pattern_gen.sv
// Pipelined VGA pixel pattern generator: solid, colour bars, checkerboard and scrolling bars.
// Two pixel_tick stages from timing inputs to RGB/syncs; mode and scroll latch at frame start.
module pixel_pattern_gen #(
    parameter int unsigned COLOR_BITS  = 4,
    parameter int unsigned X_BITS      = 10,
    parameter int unsigned Y_BITS      = 10,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned BAR_W       = 80,
    parameter int unsigned CHECK_SHIFT = 5,
    parameter int unsigned SCROLL_STEP = 4
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic                  pixel_tick,
    input  logic                  video_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [X_BITS-1:0]     x,
    input  logic [Y_BITS-1:0]     y,
    input  logic [2:0]            sw,
    input  logic [1:0]            mode,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  hsync,
    output logic                  vsync
);

    localparam int unsigned SumW = X_BITS + 1;

    typedef enum logic [1:0] {
        ModeSolid   = 2'd0,
        ModeBars    = 2'd1,
        ModeChecker = 2'd2,
        ModeScroll  = 2'd3
    } mode_e;

    mode_e                  mode_q, mode_d;
    logic [X_BITS-1:0]      scroll_q, scroll_d;
    logic [SumW-1:0]        scroll_sum;
    logic                   frame_start;

    logic [SumW-1:0]        x_sum;
    logic [SumW-1:0]        x_eff;
    logic [2:0]             bar_idx;
    logic [2:0]             bar_code;
    logic                   checker_on;
    logic [2:0]             code_d;

    logic [2:0]             code_s1_q;
    logic                   video_on_s1_q;
    logic                   hsync_s1_q;
    logic                   vsync_s1_q;

    logic [COLOR_BITS-1:0]  red_q, green_q, blue_q;
    logic                   hsync_q, vsync_q;

    assign frame_start = pixel_tick && (x == '0) && (y == '0);

    // Frame-level state; the frame-start pixel itself already sees the new values.
    always_comb begin
        mode_d     = mode_q;
        scroll_d   = scroll_q;
        scroll_sum = {1'b0, scroll_q} + SumW'(SCROLL_STEP);
        if (frame_start) begin
            mode_d = mode_e'(mode);
            if (mode_e'(mode) == ModeScroll) begin
                if (scroll_sum >= SumW'(H_ACTIVE)) begin
                    scroll_d = X_BITS'(scroll_sum - SumW'(H_ACTIVE));
                end else begin
                    scroll_d = X_BITS'(scroll_sum);
                end
            end else begin
                scroll_d = '0;
            end
        end
    end

    always_comb begin
        x_sum = {1'b0, x} + {1'b0, scroll_d};
        x_eff = {1'b0, x};
        if (mode_d == ModeScroll) begin
            x_eff = (x_sum >= SumW'(H_ACTIVE)) ? (x_sum - SumW'(H_ACTIVE)) : x_sum;
        end
    end

    // Bar index by threshold count, so anything past the last bar saturates at 7.
    always_comb begin
        bar_idx = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (x_eff >= SumW'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end
    end

    always_comb begin
        case (bar_idx)
            3'd0:    bar_code = 3'd7;
            3'd1:    bar_code = 3'd3;
            3'd2:    bar_code = 3'd6;
            3'd3:    bar_code = 3'd2;
            3'd4:    bar_code = 3'd5;
            3'd5:    bar_code = 3'd1;
            3'd6:    bar_code = 3'd4;
            default: bar_code = 3'd0;
        endcase
    end

    assign checker_on = x[CHECK_SHIFT] ^ y[CHECK_SHIFT];

    always_comb begin
        code_d = 3'd0;
        unique case (mode_d)
            ModeSolid:             code_d = sw;
            ModeBars, ModeScroll:  code_d = bar_code;
            ModeChecker:           code_d = checker_on ? sw : 3'd0;
            default:               code_d = 3'd0;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            mode_q        <= ModeSolid;
            scroll_q      <= '0;
            code_s1_q     <= 3'd0;
            video_on_s1_q <= 1'b0;
            hsync_s1_q    <= 1'b0;
            vsync_s1_q    <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
        end else if (pixel_tick) begin
            mode_q        <= mode_d;
            scroll_q      <= scroll_d;
            code_s1_q     <= code_d;
            video_on_s1_q <= video_on;
            hsync_s1_q    <= hsync_in;
            vsync_s1_q    <= vsync_in;
            red_q         <= {COLOR_BITS{code_s1_q[0] & video_on_s1_q}};
            green_q       <= {COLOR_BITS{code_s1_q[1] & video_on_s1_q}};
            blue_q        <= {COLOR_BITS{code_s1_q[2] & video_on_s1_q}};
            hsync_q       <= hsync_s1_q;
            vsync_q       <= vsync_s1_q;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule

// File: doc/pixel_pattern_gen.md
Name: pixel_pattern_gen

Overview:
- Parametrised, pipelined successor of the combinational switch-colour pixel block.
- Sits between the VGA timing generator (x, y, video_on, syncs, pixel_tick) and the DAC pins.
- Generates one of four patterns: solid switch colour, 8 colour bars, checkerboard, horizontally scrolling bars.
- Colour depth is generic; syncs are delayed so they stay aligned with the registered RGB.

Parameters:
COLOR_BITS, 4, bits per colour channel; full intensity = all ones
X_BITS, 10, width of x coordinate
Y_BITS, 10, width of y coordinate
H_ACTIVE, 640, visible pixels per line; also the scroll wrap modulus
BAR_W, 80, colour bar width in pixels; bar index = min(7, x_eff / BAR_W)
CHECK_SHIFT, 5, checker cell size = 2^CHECK_SHIFT pixels
SCROLL_STEP, 4, pixels added to the scroll offset per frame in scroll mode

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous, active-low reset
pixel_tick  in  1  pixel enable; all pipeline registers advance only when high
video_on  in  1  visible-area flag from the timing generator
hsync_in  in  1  horizontal sync from the timing generator
vsync_in  in  1  vertical sync from the timing generator
x  in  X_BITS  current pixel column
y  in  Y_BITS  current pixel row
sw  in  3  colour code: bit0 = R, bit1 = G, bit2 = B
mode  in  2  0 solid, 1 bars, 2 checker, 3 scroll bars
red  out  COLOR_BITS  red channel
green  out  COLOR_BITS  green channel
blue  out  COLOR_BITS  blue channel
hsync  out  1  hsync_in delayed 2 ticks
vsync  out  1  vsync_in delayed 2 ticks

Behaviour:
- Reset (reset = 0, asynchronous):
  - all pipeline registers clear; red, green, blue = 0; hsync = vsync = 0
  - latched mode = 0; scroll offset = 0
- With reset high, registers change only on rising clk_100MHz edges where pixel_tick = 1. With pixel_tick = 0 every register holds.
- Frame start is defined as pixel_tick && x == 0 && y == 0. On frame start:
  - mode_q <= mode. Mode changes mid-frame are ignored until the next frame start.
  - If the new mode is 3: scroll <= scroll + SCROLL_STEP, minus H_ACTIVE if the sum is >= H_ACTIVE (wraps within [0, H_ACTIVE-1]).
  - If the new mode is not 3: scroll <= 0.
- Frame-start pixel uses the newly latched mode and scroll, computed combinationally from the next-state values.
- Stage 1, per tick:
  - x_eff = x + scroll, wrapped mod H_ACTIVE when in mode 3; otherwise x_eff = x.
  - Colour code by mode:
    - mode 0: sw
    - modes 1 and 3: bar table for bars 0..7 = 7, 3, 6, 2, 5, 1, 4, 0 (white, yellow, cyan, green, magenta, red, blue, black)
    - mode 2: sw if x[CHECK_SHIFT] ^ y[CHECK_SHIFT] is 1, else 0
  - Registers: code_d1, video_on_d1, hsync_d1, vsync_d1.
- Stage 2, per tick:
  - Each channel = all ones if its code bit is set and video_on_d1 = 1, else 0.
  - hsync and vsync take the d1 values.
- Latency: exactly 2 pixel_ticks from inputs to outputs, for RGB and syncs alike.
- x >= H_ACTIVE with video_on = 1 is out of contract; the bar index still saturates at 7 and there is no X propagation.
- sw changes take effect on the next tick in modes 0 and 2; there is no frame latching for sw.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronously). After release, the first frame start latches the mode.

Test Plan:
- Reset: hold reset = 0 with pixel_tick toggling -> red/green/blue = 0 and hsync/vsync = 0 throughout; after release with mode = 0 and sw = 3'b011, video_on = 1 -> red = 4'hF, green = 4'hF, blue = 0 exactly 2 ticks later.
- Blanking and latency: mode 0, sw = 3'b111, video_on pulses low for 1 tick -> RGB = 0 for exactly 1 tick, 2 ticks after the pulse; hsync_in pulse appears on hsync in the same cycle alignment.
- Bars: mode 1, sweep x = 0..639 on one line -> codes 7, 3, 6, 2, 5, 1, 4, 0 change at x = 80, 160, …, 560 (seen 2 ticks later); x = 79 gives white, x = 80 gives yellow (R = G = F, B = 0).
- Checker: mode 2, sw = 3'b100, CHECK_SHIFT = 5 -> (x = 32, y = 0) blue = F; (x = 32, y = 32) RGB = 0; (x = 0, y = 0) RGB = 0.
- Scroll wrap: mode 3 over 161 frame starts, SCROLL_STEP = 4 -> scroll = 4, 8, …, 636, then 0; at scroll = 636, pixel x = 4 maps to x_eff = 0 (white); switching mode to 0 mid-frame has no effect until the next frame start, where scroll clears to 0.
- pixel_tick stall: hold pixel_tick = 0 for 10 cycles while changing x, sw, and video_on -> outputs remain constant.
